sweep_sequencer: RTL and testbench

- Top-level scheduler for the overclocking test platform.
- Steps the MMCM through a table of frequency settings. At each setting it runs a fixed number of capture/readout passes through the capture controller (write phase into BRAM, then read phase out of BRAM).
- Sits between host start/abort and the MMCM reconfiguration block and capture controller.
- Owns the write_enable/read_enable strobes that the capture controller consumes.

---
 rtl/sweep_pkg.sv | 21 ++
 rtl/sweep_timer.sv | 40 ++++
 rtl/sweep_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep sequencer: FSM state encoding, run index width
// and a helper that sizes counters from their terminal value.
package sweep_pkg;

    localparam int RunWL   = 8;
    localparam int StateWL = 3;

    localparam logic [StateWL-1:0] IDLE      = 3'd0;
    localparam logic [StateWL-1:0] CFG       = 3'd1;
    localparam logic [StateWL-1:0] LOCK_WAIT = 3'd2;
    localparam logic [StateWL-1:0] WRITE     = 3'd3;
    localparam logic [StateWL-1:0] READ      = 3'd4;
    localparam logic [StateWL-1:0] READ_WAIT = 3'd5;
    localparam logic [StateWL-1:0] NEXT      = 3'd6;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
// The count holds once it reaches TC so the flag stays asserted until cleared.
module sweep_timer #(
    parameter int W  = 8,
    parameter int TC = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == W'(TC));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Sweep sequencer: steps the MMCM through NUM_STEPS settings and runs RUNS_PER_STEP
// capture/readout passes at each. Define SWEEP_LOCK_TIMEOUT_EN for the lock watchdog.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int StepWL        = 6,
    parameter int NUM_STEPS     = 32,
    parameter int RUNS_PER_STEP = 4,
    parameter int LOCK_SETTLE   = 16,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              cfg_req,
    output logic [StepWL-1:0] cfg_step,
    input  logic              cfg_ack,
    input  logic              mmcm_lock,
    output logic              write_enable,
    input  logic              write_done,
    output logic              read_enable,
    input  logic              bram_read_finish,
    output logic [RunWL-1:0]  run_idx,
    output logic              busy,
    output logic              sweep_done,
    output logic              lock_err
);

    localparam int                SettleWL = cnt_width(LOCK_SETTLE);
    localparam logic [StepWL-1:0] LastStep = StepWL'(NUM_STEPS - 1);
    localparam logic [RunWL-1:0]  LastRun  = RunWL'(RUNS_PER_STEP - 1);

    if (NUM_STEPS < 1 || NUM_STEPS > (1 << StepWL)) begin : g_bad_num_steps
        $error("sweep_sequencer: NUM_STEPS out of range");
    end
    if (RUNS_PER_STEP < 1 || RUNS_PER_STEP > 255) begin : g_bad_runs
        $error("sweep_sequencer: RUNS_PER_STEP out of range");
    end
    if (LOCK_SETTLE < 1 || LOCK_TIMEOUT < 1) begin : g_bad_lock
        $error("sweep_sequencer: LOCK_SETTLE and LOCK_TIMEOUT must be at least 1");
    end

    logic [StateWL-1:0] state_q, state_d;
    logic [StepWL-1:0]  cfg_step_q, cfg_step_d;
    logic [RunWL-1:0]   run_idx_q, run_idx_d;

    logic settle_clr;
    logic settle_tc;
    logic lock_settled;
    logic last_run;
    logic last_step;
    logic timeout_hit;

    // Settle counter: counts consecutive locked cycles in LOCK_WAIT, restarts on any drop.
    assign settle_clr   = (state_q != LOCK_WAIT) || !mmcm_lock;
    assign lock_settled = (state_q == LOCK_WAIT) && mmcm_lock && settle_tc;

    sweep_timer #(
        .W  (SettleWL),
        .TC (LOCK_SETTLE - 1)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .clr      (settle_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (1'b1),
        .tc       (settle_tc)
    );

`ifdef SWEEP_LOCK_TIMEOUT_EN
    localparam int WdWL = cnt_width(LOCK_TIMEOUT);

    logic wd_clr;
    logic wd_tc;
    logic lock_err_q, lock_err_d;

    // Watchdog restarts on every LOCK_WAIT entry because it is cleared in all other states.
    assign wd_clr      = (state_q != LOCK_WAIT);
    assign timeout_hit = (state_q == LOCK_WAIT) && wd_tc && !lock_settled && !abort;

    sweep_timer #(
        .W  (WdWL),
        .TC (LOCK_TIMEOUT - 1)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (1'b1),
        .tc       (wd_tc)
    );

    always_comb begin
        lock_err_d = lock_err_q;
        if (state_q == IDLE && start && !abort) begin
            lock_err_d = 1'b0;
        end else if (timeout_hit) begin
            lock_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    assign timeout_hit = 1'b0;
    assign lock_err    = 1'b0;
`endif

    assign last_run  = (run_idx_q == LastRun);
    assign last_step = (cfg_step_q == LastStep);

    always_comb begin
        state_d    = state_q;
        cfg_step_d = cfg_step_q;
        run_idx_d  = run_idx_q;
        if (state_q == IDLE) begin
            if (start && !abort) begin
                state_d    = CFG;
                cfg_step_d = '0;
                run_idx_d  = '0;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                CFG: begin
                    if (cfg_ack) state_d = LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    if (lock_settled) begin
                        state_d = WRITE;
                    end else if (timeout_hit) begin
                        state_d = IDLE;
                    end
                end
                WRITE: begin
                    if (write_done) state_d = READ;
                end
                READ: begin
                    state_d = READ_WAIT;
                end
                READ_WAIT: begin
                    if (bram_read_finish) state_d = NEXT;
                end
                NEXT: begin
                    if (!last_run) begin
                        run_idx_d = run_idx_q + 1'b1;
                        state_d   = WRITE;
                    end else if (!last_step) begin
                        cfg_step_d = cfg_step_q + 1'b1;
                        run_idx_d  = '0;
                        state_d    = CFG;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_step_q <= '0;
            run_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cfg_step_q <= cfg_step_d;
            run_idx_q  <= run_idx_d;
        end
    end

    assign cfg_req      = (state_q == CFG);
    assign write_enable = (state_q == WRITE);
    assign read_enable  = (state_q == READ);
    assign busy         = (state_q != IDLE);
    assign cfg_step     = cfg_step_q;
    assign run_idx      = run_idx_q;
    // Completion pulse is suppressed when the same cycle is aborted or reset.
    assign sweep_done   = (state_q == NEXT) && last_run && last_step && !abort && !rst;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Randomized bench for sweep_sequencer: a reactive environment plays MMCM and capture
// controller, and observed cfg/readout sequences and timings are checked against a reference.
module tb_sweep_sequencer;

    localparam int STEP_WL = 6;
    localparam int N_STEPS = 2;
    localparam int N_RUNS  = 2;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 100;

    localparam int M_RAND    = 0;
    localparam int M_BASIC   = 1;
    localparam int M_START   = 2;
    localparam int M_ABORT   = 3;
    localparam int M_RST     = 4;
    localparam int M_LOCKLOW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic               cfg_req;
    logic [STEP_WL-1:0] cfg_step;
    logic               cfg_ack;
    logic               mmcm_lock;
    logic               write_enable;
    logic               write_done;
    logic               read_enable;
    logic               bram_read_finish;
    logic [7:0]         run_idx;
    logic               busy;
    logic               sweep_done;
    logic               lock_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sweep_sequencer #(
        .StepWL        (STEP_WL),
        .NUM_STEPS     (N_STEPS),
        .RUNS_PER_STEP (N_RUNS),
        .LOCK_SETTLE   (SETTLE),
        .LOCK_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_req          (cfg_req),
        .cfg_step         (cfg_step),
        .cfg_ack          (cfg_ack),
        .mmcm_lock        (mmcm_lock),
        .write_enable     (write_enable),
        .write_done       (write_done),
        .read_enable      (read_enable),
        .bram_read_finish (bram_read_finish),
        .run_idx          (run_idx),
        .busy             (busy),
        .sweep_done       (sweep_done),
        .lock_err         (lock_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_cfg_req"}, cfg_req, 0);
        chk({pfx, "_we"}, write_enable, 0);
        chk({pfx, "_re"}, read_enable, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, sweep_done, 0);
    endtask

    // One sweep with the environment reacting cycle by cycle; mode selects the disturbance.
    task automatic run_sweep(input int mode);
        bit fixed = (mode == M_BASIC);
        int cyc = 0;
        int obs_cfg[$];
        int obs_rd[$];
        int done_cnt = 0;
        int done_cyc = -1;
        bit finished = 0;
        bit prev_cfg = 0, prev_we = 0, prev_re = 0;
        int ack_wait = 0, ack_cyc = -1;
        int lk_t = -1, lk_l = 0;
        bit lk_glitch = 0;
        bit we_pending = 0;
        int exp_we = 0;
        int wd_wait = 0, rf_wait = 0;
        bit wd_act = 0, rf_act = 0;
        int abort_at = -1, ab_step = 0, ab_run = 0;
        int inj_cyc = -1, inj_step = 0, inj_run = 0;
        bit inj = 0;

        while (!finished) begin
            @(negedge clk);
            start = (cyc == 0);
            abort = 1'b0;
            cfg_ack = 1'b0;
            bram_read_finish = 1'b0;
            rst = 1'b0;
            if (cyc == 0) begin
                mmcm_lock = 1'b0;
                write_done = 1'b0;
            end
            if (cyc == 1) begin
                chk("go_busy", busy, 1);
                chk("lock_err_clr", lock_err, 0);
            end

            if (sweep_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_step", cfg_step, N_STEPS - 1);
                chk("done_run", run_idx, N_RUNS - 1);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("idle_after_done", busy, 0);
                finished = 1;
            end

            if (cfg_req && !prev_cfg) begin
                if (obs_cfg.size() == 0) chk("first_step", cfg_step, 0);
                obs_cfg.push_back(int'(cfg_step));
                ack_wait = fixed ? 3 : $urandom_range(1, 6);
                mmcm_lock = 1'b0;
                lk_t = -1;
            end
            if (cfg_req) begin
                if (ack_wait == 0) begin
                    cfg_ack = 1'b1;
                    ack_cyc = cyc;
                    lk_t = 0;
                    lk_l = fixed ? 20 : (mode == M_LOCKLOW ? (1 << 30) : $urandom_range(1, 25));
                    lk_glitch = fixed ? 1'b0 : (obs_cfg.size() == 1 || $urandom_range(0, 2) == 0);
                    exp_we = ack_cyc + lk_l + (lk_glitch ? 11 : 0) + SETTLE;
                    we_pending = (mode != M_LOCKLOW);
                end else begin
                    ack_wait--;
                end
            end
            if (lk_t >= 0) begin
                int k;
                k = lk_t - lk_l;
                if (k < 0) mmcm_lock = 1'b0;
                else if (lk_glitch && k == 10) mmcm_lock = 1'b0;
                else mmcm_lock = 1'b1;
                lk_t++;
            end

            if (write_enable && !prev_we) begin
                if (we_pending) begin
                    chk("we_rise_cycle", cyc, exp_we);
                    we_pending = 0;
                end
                wd_wait = fixed ? 600 : $urandom_range(1, 40);
                wd_act = 1;
            end
            if (wd_act) begin
                if (wd_wait == 0) begin
                    write_done = 1'b1;
                    wd_act = 0;
                end else begin
                    wd_wait--;
                end
            end

            if (read_enable) begin
                chk("re_single_cycle", prev_re, 0);
                obs_rd.push_back(int'(cfg_step) * 256 + int'(run_idx));
                write_done = 1'b0;
                if (mode == M_ABORT && cfg_step == 1 && run_idx == 1) begin
                    rf_wait = 60;
                    abort_at = cyc + 1 + $urandom_range(0, 5);
                end else begin
                    rf_wait = fixed ? 512 : $urandom_range(1, 40);
                end
                rf_act = 1;
            end
            if (rf_act) begin
                if (rf_wait == 0) begin
                    bram_read_finish = 1'b1;
                    rf_act = 0;
                end else begin
                    rf_wait--;
                end
            end

            if ((mode == M_START || mode == M_RST) && !inj && write_enable && wd_act
                && wd_wait >= 2 && cfg_step == 1) begin
                inj = 1;
                inj_cyc = cyc;
                inj_step = int'(cfg_step);
                inj_run = int'(run_idx);
                if (mode == M_START) start = 1'b1;
                else rst = 1'b1;
            end else if (inj && cyc == inj_cyc + 1) begin
                if (mode == M_START) begin
                    chk("start_busy_we", write_enable, 1);
                    chk("start_busy_step", cfg_step, inj_step);
                    chk("start_busy_run", run_idx, inj_run);
                    chk("start_busy_cfg", cfg_req, 0);
                end else begin
                    check_quiet("rst");
                    chk("rst_step", cfg_step, 0);
                    chk("rst_run", run_idx, 0);
                    chk("rst_lock_err", lock_err, 0);
                    finished = 1;
                end
            end

            if (mode == M_LOCKLOW && ack_cyc >= 0) begin
`ifdef SWEEP_LOCK_TIMEOUT_EN
                if (lock_err) begin
                    chk("timeout_cycle", cyc, ack_cyc + 1 + TIMEOUT);
                    chk("timeout_idle", busy, 0);
                    chk("timeout_no_done", sweep_done, 0);
                    finished = 1;
                end
`else
                if (cyc == ack_cyc + 300) begin
                    chk("nowd_lock_err", lock_err, 0);
                    chk("nowd_busy", busy, 1);
                    chk("nowd_we", write_enable, 0);
                    abort_at = cyc;
                end
`endif
            end

            if (cyc == abort_at) begin
                abort = 1'b1;
                ab_step = int'(cfg_step);
                ab_run = int'(run_idx);
            end else if (abort_at >= 0 && cyc == abort_at + 1) begin
                check_quiet("abort");
                chk("abort_step", cfg_step, ab_step);
                chk("abort_run", run_idx, ab_run);
                finished = 1;
            end

            if (cyc > 20000) begin
                chk("cycle_budget", 0, 1);
                finished = 1;
            end
            prev_cfg = cfg_req;
            prev_we = write_enable;
            prev_re = read_enable;
            cyc++;
        end

        if (mode == M_RAND || mode == M_BASIC || mode == M_START || mode == M_ABORT) begin
            chk("n_cfg_req", obs_cfg.size(), N_STEPS);
            chk("n_read_enable", obs_rd.size(), N_STEPS * N_RUNS);
            for (int s = 0; s < N_STEPS; s++) begin
                if (s < obs_cfg.size()) chk("cfg_step_seq", obs_cfg[s], s);
                for (int r = 0; r < N_RUNS; r++) begin
                    if (s * N_RUNS + r < obs_rd.size())
                        chk("read_seq", obs_rd[s * N_RUNS + r], s * 256 + r);
                end
            end
        end
        chk("sweep_done_count", done_cnt,
            (mode == M_RAND || mode == M_BASIC || mode == M_START) ? 1 : 0);

        mmcm_lock = 1'b0;
        write_done = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
        cfg_ack = 1'b0;
        bram_read_finish = 1'b0;
        @(negedge clk);
        chk("post_idle_busy", busy, 0);
        chk("post_idle_done", sweep_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_ack = 1'b0;
        mmcm_lock = 1'b0;
        write_done = 1'b0;
        bram_read_finish = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        chk("reset_step", cfg_step, 0);
        chk("reset_run", run_idx, 0);
        chk("reset_lock_err", lock_err, 0);
        rst = 1'b0;

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_cfg", cfg_req, 0);

        run_sweep(M_BASIC);
        run_sweep(M_START);
        run_sweep(M_ABORT);
        run_sweep(M_RST);
        run_sweep(M_RAND);
        run_sweep(M_LOCKLOW);
        repeat (3) run_sweep(M_RAND);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
